// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding and operand-forwarding select codes.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      SQUASH   = 2'd2
   } hz_state_t;

   localparam logic [1:0] FWD_REG = 2'd0;  // register file read
   localparam logic [1:0] FWD_EXE = 2'd1;  // EXE-stage ALU result
   localparam logic [1:0] FWD_MEM = 2'd2;  // MEM-stage ALU result
   localparam logic [1:0] FWD_LD  = 2'd3;  // MEM-stage load data

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Operand-source select for one ID-stage source register. The nearest
// producer wins; an EXE load cannot be forwarded yet, so it falls through
// to MEM (the load-use stall covers that case). Register 0 never forwards.
module fwd_select
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] i_src,
   input  logic [4:0] i_exe_rn,
   input  logic       i_exe_wreg,
   input  logic       i_exe_m2reg,
   input  logic [4:0] i_mem_rn,
   input  logic       i_mem_wreg,
   input  logic       i_mem_m2reg,
   output logic [1:0] o_sel
);

   // priority select: r0, EXE ALU, MEM load, MEM ALU, regfile
   always_comb begin
      o_sel = FWD_REG;
      if (i_src == 5'd0)
         o_sel = FWD_REG;
      else if (i_exe_wreg && (i_exe_rn == i_src) && !i_exe_m2reg)
         o_sel = FWD_EXE;
      else if (i_mem_wreg && i_mem_m2reg && (i_mem_rn == i_src))
         o_sel = FWD_LD;
      else if (i_mem_wreg && (i_mem_rn == i_src))
         o_sel = FWD_MEM;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch wrong-path squash,
// memory-busy freeze and operand forwarding selects.
// Optional feature: define HAZ_PERF_CNT_EN to add saturating stall/flush
// cycle counters (stall_cnt, flush_cnt).
// Note: Resetn is active-high and synchronous despite its name.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int BRANCH_SLOTS = 1,
   parameter int PERF_W       = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_redirect,
   input  logic [4:0]        exe_rn,
   input  logic [4:0]        mem_rn,
   input  logic              exe_wreg,
   input  logic              exe_m2reg,
   input  logic              mem_wreg,
   input  logic              mem_m2reg,
   input  logic              mem_busy,
   output logic              pc_wen,
   output logic              ifid_wen,
   output logic              exemem_wen,
   output logic              memwb_wen,
   output logic              ifid_flush,
   output logic              idexe_bubble,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
`endif
);

   if (PERF_W < 1 || (BRANCH_SLOTS != 1 && BRANCH_SLOTS != 2)) begin : g_bad_param
      $error("pipe_hazard_ctrl: BRANCH_SLOTS must be 1 or 2, PERF_W >= 1");
   end

   hz_state_t  r_state;
   hz_state_t  w_state_nxt;
   logic [1:0] r_slot_cnt;
   logic [1:0] w_slot_cnt_nxt;
   logic       w_lu;
   logic       w_pc_wen, w_ifid_wen, w_exemem_wen, w_memwb_wen;
   logic       w_flush, w_bubble;

   assign w_lu = exe_m2reg && exe_wreg && (exe_rn != 5'd0) &&
                 ((id_use_rs && (exe_rn == id_rs)) ||
                  (id_use_rt && (exe_rn == id_rt)));

   // control decode: reset forces idle outputs, mem_busy freezes everything,
   // otherwise stall/flush per state; the load-use stall outranks a redirect
   // because the branch operands are not ready yet
   always_comb begin
      w_pc_wen       = 1'b1;
      w_ifid_wen     = 1'b1;
      w_exemem_wen   = 1'b1;
      w_memwb_wen    = 1'b1;
      w_flush        = 1'b0;
      w_bubble       = 1'b0;
      w_state_nxt    = r_state;
      w_slot_cnt_nxt = r_slot_cnt;
      if (Resetn) begin
         w_state_nxt    = RUN;
         w_slot_cnt_nxt = 2'd0;
      end else if (mem_busy) begin
         w_pc_wen     = 1'b0;
         w_ifid_wen   = 1'b0;
         w_exemem_wen = 1'b0;
         w_memwb_wen  = 1'b0;
      end else begin
         case (r_state)
            RUN, LU_STALL: begin
               if ((r_state == RUN) && w_lu) begin
                  w_pc_wen    = 1'b0;
                  w_ifid_wen  = 1'b0;
                  w_bubble    = 1'b1;
                  w_state_nxt = LU_STALL;
               end else if (id_redirect) begin
                  w_flush = 1'b1;
                  if (BRANCH_SLOTS > 1) begin
                     w_state_nxt    = SQUASH;
                     w_slot_cnt_nxt = 2'(BRANCH_SLOTS - 1);
                  end else begin
                     w_state_nxt = RUN;
                  end
               end else begin
                  w_state_nxt = RUN;
               end
            end
            SQUASH: begin
               w_flush        = 1'b1;
               w_slot_cnt_nxt = r_slot_cnt - 2'd1;
               if (r_slot_cnt <= 2'd1)
                  w_state_nxt = RUN;
            end
            default: begin
               w_state_nxt    = RUN;
               w_slot_cnt_nxt = 2'd0;
            end
         endcase
      end
   end

   // state and squash slot counter
   always_ff @(posedge Clock) begin
      if (Resetn) begin
         r_state    <= RUN;
         r_slot_cnt <= 2'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_slot_cnt <= w_slot_cnt_nxt;
      end
   end

   assign pc_wen       = w_pc_wen;
   assign ifid_wen     = w_ifid_wen;
   assign exemem_wen   = w_exemem_wen;
   assign memwb_wen    = w_memwb_wen;
   assign ifid_flush   = w_flush;
   assign idexe_bubble = w_bubble;

`ifdef HAZ_PERF_CNT_EN
   logic [PERF_W-1:0] r_stall_cnt;
   logic [PERF_W-1:0] r_flush_cnt;

   // saturating counts of bubble and flush cycles
   always_ff @(posedge Clock) begin
      if (Resetn) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_bubble && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

   fwd_select u_fwd_rs (
      .i_src       (id_rs),
      .i_exe_rn    (exe_rn),
      .i_exe_wreg  (exe_wreg),
      .i_exe_m2reg (exe_m2reg),
      .i_mem_rn    (mem_rn),
      .i_mem_wreg  (mem_wreg),
      .i_mem_m2reg (mem_m2reg),
      .o_sel       (fwd_a)
   );

   fwd_select u_fwd_rt (
      .i_src       (id_rt),
      .i_exe_rn    (exe_rn),
      .i_exe_wreg  (exe_wreg),
      .i_exe_m2reg (exe_m2reg),
      .i_mem_rn    (mem_rn),
      .i_mem_wreg  (mem_wreg),
      .i_mem_m2reg (mem_m2reg),
      .o_sel       (fwd_b)
   );

endmodule
